// File: rtl/hop_select_kernel.sv
// hop_select_kernel: four-stage Bluetooth basic-hopping channel selection kernel.
// Define HOP_PAGE_EN to compile in page-mode X computation and regi_koffset_b train select.
module hop_select_kernel (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        hop_start_p,
    input  logic [1:0]  hop_mode,
    input  logic [27:0] hop_clk,
    input  logic [27:0] hop_addr,
    input  logic        regi_koffset_b,
    output logic        hop_valid_p,
    output logic [6:0]  hop_chan,
    output logic        hop_busy
);

    function automatic logic [4:0] bfly(input logic [4:0] z, input logic en,
                                        input logic [2:0] i, input logic [2:0] j);
        logic [4:0] r;
        r = z;
        if (en) begin
            r[i] = z[j];
            r[j] = z[i];
        end
        return r;
    endfunction

    // Butterflies are applied from P13 (first stage) down to P0 (last stage).
    function automatic logic [4:0] perm5(input logic [4:0] z_in, input logic [13:0] p);
        logic [4:0] z;
        z = z_in;
        z = bfly(z, p[13], 3'd1, 3'd2);
        z = bfly(z, p[12], 3'd0, 3'd3);
        z = bfly(z, p[11], 3'd1, 3'd3);
        z = bfly(z, p[10], 3'd2, 3'd4);
        z = bfly(z, p[9],  3'd0, 3'd3);
        z = bfly(z, p[8],  3'd1, 3'd4);
        z = bfly(z, p[7],  3'd3, 3'd4);
        z = bfly(z, p[6],  3'd0, 3'd2);
        z = bfly(z, p[5],  3'd1, 3'd3);
        z = bfly(z, p[4],  3'd0, 3'd4);
        z = bfly(z, p[3],  3'd3, 3'd4);
        z = bfly(z, p[2],  3'd1, 3'd2);
        z = bfly(z, p[1],  3'd2, 3'd3);
        z = bfly(z, p[0],  3'd0, 3'd1);
        return z;
    endfunction

    logic       s1_valid_q, s1_valid_d;
    logic [4:0] s1_x_q, s1_x_d;
    logic       s1_y1_q, s1_y1_d;
    logic [4:0] s1_a_q, s1_a_d;
    logic [3:0] s1_b_q, s1_b_d;
    logic [4:0] s1_c_q, s1_c_d;
    logic [8:0] s1_d_q, s1_d_d;
    logic [6:0] s1_e_q, s1_e_d;
    logic [6:0] s1_f_q, s1_f_d;

    logic       s2_valid_q, s2_valid_d;
    logic [4:0] s2_z_q, s2_z_d;
    logic       s2_y1_q, s2_y1_d;
    logic [4:0] s2_c_q, s2_c_d;
    logic [8:0] s2_d_q, s2_d_d;
    logic [6:0] s2_e_q, s2_e_d;
    logic [6:0] s2_f_q, s2_f_d;

    logic       s3_valid_q, s3_valid_d;
    logic [4:0] s3_perm_q, s3_perm_d;
    logic       s3_y1_q, s3_y1_d;
    logic [6:0] s3_e_q, s3_e_d;
    logic [6:0] s3_f_q, s3_f_d;

    logic       hop_valid_q, hop_valid_d;
    logic [6:0] hop_chan_q, hop_chan_d;
    logic       hop_busy_q, hop_busy_d;

    logic       sel_scan;
    logic       sel_page;
    logic [6:0] f_mod;
    logic [8:0] sum;
    logic [6:0] k;
    logic [5:0] k_hi;

    assign sel_scan = (hop_mode == 2'd1);
    assign f_mod    = 7'(({hop_clk[27:7], 4'b0000}) % 25'd79);

`ifdef HOP_PAGE_EN
    logic [4:0] koffset;
    logic [3:0] page_phase;
    logic [4:0] page_x;

    always_comb begin
        koffset    = regi_koffset_b ? 5'd8 : 5'd24;
        page_phase = {hop_clk[4:2], hop_clk[0]} - hop_clk[15:12];
        page_x     = hop_clk[16:12] + koffset + {1'b0, page_phase};
    end

    assign sel_page = (hop_mode == 2'd2);
`else
    logic unused_page_inputs;
    assign unused_page_inputs = regi_koffset_b ^ hop_clk[0];
    assign sel_page = 1'b0;
`endif

    always_comb begin
        s1_valid_d = hop_start_p;
        s1_x_d     = hop_clk[6:2];
        s1_y1_d    = hop_clk[1];
        s1_a_d     = hop_addr[27:23];
        s1_b_d     = hop_addr[22:19];
        s1_c_d     = {hop_addr[8], hop_addr[6], hop_addr[4], hop_addr[2], hop_addr[0]};
        s1_d_d     = hop_addr[18:10];
        s1_e_d     = {hop_addr[13], hop_addr[11], hop_addr[9], hop_addr[7],
                      hop_addr[5], hop_addr[3], hop_addr[1]};
        s1_f_d     = f_mod;
        if (sel_scan) begin
            s1_x_d  = hop_clk[16:12];
            s1_y1_d = 1'b0;
            s1_f_d  = 7'd0;
        end else if (sel_page) begin
`ifdef HOP_PAGE_EN
            s1_x_d  = page_x;
`endif
            s1_f_d  = 7'd0;
        end else begin
            s1_a_d = s1_a_d ^ hop_clk[25:21];
            s1_c_d = s1_c_d ^ hop_clk[20:16];
            s1_d_d = s1_d_d ^ hop_clk[15:7];
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_z_d     = ((s1_x_q + s1_a_q) ^ {1'b0, s1_b_q}) ^ {5{s1_y1_q}};
        s2_y1_d    = s1_y1_q;
        s2_c_d     = s1_c_q;
        s2_d_d     = s1_d_q;
        s2_e_d     = s1_e_q;
        s2_f_d     = s1_f_q;

        s3_valid_d = s2_valid_q;
        s3_perm_d  = perm5(s2_z_q, {s2_c_q ^ {5{s2_y1_q}}, s2_d_q});
        s3_y1_d    = s2_y1_q;
        s3_e_d     = s2_e_q;
        s3_f_d     = s2_f_q;
    end

    // Sum never exceeds 268, so three conditional subtractions fully reduce it mod 79.
    always_comb begin
        sum = {4'd0, s3_perm_q} + {2'd0, s3_e_q} + {2'd0, s3_f_q} + {3'd0, s3_y1_q, 5'd0};
        if (sum >= 9'd79) sum = sum - 9'd79;
        if (sum >= 9'd79) sum = sum - 9'd79;
        if (sum >= 9'd79) sum = sum - 9'd79;
        k    = sum[6:0];
        k_hi = 6'(k - 7'd40);

        hop_valid_d = s3_valid_q;
        hop_chan_d  = hop_chan_q;
        if (s3_valid_q) begin
            hop_chan_d = (k < 7'd40) ? {k[5:0], 1'b0} : {k_hi, 1'b1};
        end
        hop_busy_d = s1_valid_d | s2_valid_d | s3_valid_d | hop_valid_d;
    end

    always_ff @(posedge clk_6M) begin
        if (rstz) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            hop_valid_q <= 1'b0;
            hop_chan_q  <= 7'd0;
            hop_busy_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            hop_valid_q <= hop_valid_d;
            hop_chan_q  <= hop_chan_d;
            hop_busy_q  <= hop_busy_d;
        end
    end

    // Datapath registers need no reset: they are only consumed alongside a valid bit.
    always_ff @(posedge clk_6M) begin
        s1_x_q    <= s1_x_d;
        s1_y1_q   <= s1_y1_d;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_c_q    <= s1_c_d;
        s1_d_q    <= s1_d_d;
        s1_e_q    <= s1_e_d;
        s1_f_q    <= s1_f_d;
        s2_z_q    <= s2_z_d;
        s2_y1_q   <= s2_y1_d;
        s2_c_q    <= s2_c_d;
        s2_d_q    <= s2_d_d;
        s2_e_q    <= s2_e_d;
        s2_f_q    <= s2_f_d;
        s3_perm_q <= s3_perm_d;
        s3_y1_q   <= s3_y1_d;
        s3_e_q    <= s3_e_d;
        s3_f_q    <= s3_f_d;
    end

    assign hop_valid_p = hop_valid_q;
    assign hop_chan    = hop_chan_q;
    assign hop_busy    = hop_busy_q;

endmodule

// File: tb/tb_hop_select_kernel.sv
// Self-checking bench for hop_select_kernel against a behavioural hop-selection model.
// Honours HOP_PAGE_EN the same way as the design when deciding how mode 2 behaves.
module tb_hop_select_kernel;

    localparam logic [27:0] SAMPLE_ADDR = 28'hA96EF25;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b1;
    logic        hop_start_p = 1'b0;
    logic [1:0]  hop_mode = 2'd0;
    logic [27:0] hop_clk = 28'd0;
    logic [27:0] hop_addr = 28'd0;
    logic        regi_koffset_b = 1'b0;
    logic        hop_valid_p;
    logic [6:0]  hop_chan;
    logic        hop_busy;

    always #5 clk_6M = ~clk_6M;

    hop_select_kernel dut (
        .clk_6M         (clk_6M),
        .rstz           (rstz),
        .hop_start_p    (hop_start_p),
        .hop_mode       (hop_mode),
        .hop_clk        (hop_clk),
        .hop_addr       (hop_addr),
        .regi_koffset_b (regi_koffset_b),
        .hop_valid_p    (hop_valid_p),
        .hop_chan       (hop_chan),
        .hop_busy       (hop_busy)
    );

    typedef struct {
        int due;
        int chan;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    logic       exp_valid = 1'b0;
    logic       exp_busy = 1'b0;
    logic [6:0] exp_chan = 7'd0;
    int         n_checks = 0;
    int         n_fails = 0;

    // Channel index computed straight from the hop-selection rules with integer arithmetic.
    function automatic int ref_chan(input logic [1:0] mode, input logic [27:0] c,
                                    input logic [27:0] a, input logic kb);
        int pa[14];
        int pb[14];
        int x, y1, aa, bb, cc, dd, ee, ff, z, p, k, lo, hi, b1, b2;
        bit page_scan;
        bit page;
        pa = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
        pb = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};
        page_scan = (mode == 2'd1);
        page = 1'b0;
`ifdef HOP_PAGE_EN
        page = (mode == 2'd2);
`endif
        aa = int'(a[27:23]);
        bb = int'(a[22:19]);
        dd = int'(a[18:10]);
        cc = 0;
        for (int i = 0; i < 5; i++) cc = cc + (int'(a[2*i]) << i);
        ee = 0;
        for (int i = 0; i < 7; i++) ee = ee + (int'(a[2*i+1]) << i);
        if (page_scan) begin
            x = int'(c[16:12]);
            y1 = 0;
            ff = 0;
        end else if (page) begin
            lo = int'({c[4:2], c[0]});
            hi = int'(c[16:12]);
            x = (hi + (kb ? 8 : 24) + ((((lo - hi) % 16) + 16) % 16)) % 32;
            y1 = int'(c[1]);
            ff = 0;
        end else begin
            x = int'(c[6:2]);
            y1 = int'(c[1]);
            aa = aa ^ int'(c[25:21]);
            cc = cc ^ int'(c[20:16]);
            dd = dd ^ int'(c[15:7]);
            ff = (16 * int'(c[27:7])) % 79;
        end
        z = (((x + aa) % 32) ^ bb) ^ (y1 * 31);
        p = ((cc ^ (y1 * 31)) << 9) + dd;
        for (int i = 13; i >= 0; i--) begin
            if (((p >> i) & 1) == 1) begin
                b1 = (z >> pa[i]) & 1;
                b2 = (z >> pb[i]) & 1;
                if (b1 != b2) z = z ^ ((1 << pa[i]) | (1 << pb[i]));
            end
        end
        k = (z + ee + ff + 32 * y1) % 79;
        return (k < 40) ? 2 * k : 2 * (k - 40) + 1;
    endfunction

    // Drives one cycle of inputs, then advances the expected outputs past that clock edge.
    task automatic step(input logic start, input logic [1:0] mode, input logic [27:0] c,
                        input logic [27:0] a, input logic kb, input logic rst);
        exp_t e;
        hop_start_p = start;
        hop_mode = mode;
        hop_clk = c;
        hop_addr = a;
        regi_koffset_b = kb;
        rstz = rst;
        @(negedge clk_6M);
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_valid = 1'b0;
            exp_busy = 1'b0;
            exp_chan = 7'd0;
        end else begin
            if (start) begin
                e.due = cyc + 3;
                e.chan = ref_chan(mode, c, a, kb);
                exp_q.push_back(e);
            end
            exp_busy = (exp_q.size() != 0);
            exp_valid = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                exp_valid = 1'b1;
                exp_chan = 7'(exp_q[0].chan);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_reset;
        step(1'b0, 2'd0, 28'd0, 28'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 28'd0, 28'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0, 28'd0, 28'd0, 1'b0, 1'b0);
            n_checks++;
            if ({hop_valid_p, hop_busy, hop_chan} !== 9'd0) begin
                n_fails++;
                $display("[TB] FAIL reset_idle cycle %0d: valid/busy/chan got %b/%b/%0d expected 0/0/0",
                         i, hop_valid_p, hop_busy, hop_chan);
            end
        end
    endtask

    task automatic test_connection;
        for (int i = 0; i < 36; i++) begin
            if (i < 32) step(1'b1, 2'd0, 28'(2 * i), SAMPLE_ADDR, 1'b0, 1'b0);
            else step(1'b0, 2'd0, 28'd0, SAMPLE_ADDR, 1'b0, 1'b0);
            n_checks++;
            if ({hop_valid_p, hop_busy, hop_chan} !== {exp_valid, exp_busy, exp_chan}) begin
                n_fails++;
                $display("[TB] FAIL connection step %0d: valid/busy/chan got %b/%b/%0d expected %b/%b/%0d",
                         i, hop_valid_p, hop_busy, hop_chan, exp_valid, exp_busy, exp_chan);
            end
        end
    endtask

    task automatic test_page_scan;
        logic [27:0] ps_clk[3];
        ps_clk = '{28'h0000000, 28'h0000FFC, 28'h0001000};
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                step(i == 0, 2'd1, ps_clk[r], SAMPLE_ADDR, 1'b0, 1'b0);
                n_checks++;
                if ({hop_valid_p, hop_busy, hop_chan} !== {exp_valid, exp_busy, exp_chan}) begin
                    n_fails++;
                    $display("[TB] FAIL page_scan clk=%h step %0d: valid/busy/chan got %b/%b/%0d expected %b/%b/%0d",
                             ps_clk[r], i, hop_valid_p, hop_busy, hop_chan, exp_valid, exp_busy, exp_chan);
                end
            end
        end
    endtask

    task automatic test_page;
        logic [27:0] pg_clk[4];
        pg_clk = '{28'h0000000, 28'h0000006, 28'h0001003, 28'h001F01D};
        for (int kb = 0; kb < 2; kb++) begin
            for (int i = 0; i < 8; i++) begin
                step(i < 4, 2'd2, pg_clk[i % 4], SAMPLE_ADDR, kb[0], 1'b0);
                n_checks++;
                if ({hop_valid_p, hop_busy, hop_chan} !== {exp_valid, exp_busy, exp_chan}) begin
                    n_fails++;
                    $display("[TB] FAIL page train %0d step %0d: valid/busy/chan got %b/%b/%0d expected %b/%b/%0d",
                             kb, i, hop_valid_p, hop_busy, hop_chan, exp_valid, exp_busy, exp_chan);
                end
            end
        end
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) step(1'b1, 2'd0, 28'($urandom), SAMPLE_ADDR, 1'b0, i == 2);
            else if (i == 10) step(1'b1, 2'd0, 28'h0000020, SAMPLE_ADDR, 1'b0, 1'b0);
            else step(1'b0, 2'd0, 28'd0, SAMPLE_ADDR, 1'b0, 1'b0);
            n_checks++;
            if ({hop_valid_p, hop_busy, hop_chan} !== {exp_valid, exp_busy, exp_chan}) begin
                n_fails++;
                $display("[TB] FAIL reset_midflight step %0d: valid/busy/chan got %b/%b/%0d expected %b/%b/%0d",
                         i, hop_valid_p, hop_busy, hop_chan, exp_valid, exp_busy, exp_chan);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n_req = 10000;
        int n_seen = 0;
        for (int i = 0; i < n_req + 5; i++) begin
            if (i < n_req)
                step(1'b1, 2'($urandom_range(3)), 28'($urandom), 28'($urandom), 1'($urandom), 1'b0);
            else
                step(1'b0, 2'd0, 28'd0, 28'd0, 1'b0, 1'b0);
            if (hop_valid_p === 1'b1) n_seen++;
            n_checks++;
            if ({hop_valid_p, hop_busy, hop_chan} !== {exp_valid, exp_busy, exp_chan}) begin
                n_fails++;
                $display("[TB] FAIL back_to_back step %0d: valid/busy/chan got %b/%b/%0d expected %b/%b/%0d",
                         i, hop_valid_p, hop_busy, hop_chan, exp_valid, exp_busy, exp_chan);
            end
            n_checks++;
            if (!(hop_chan <= 7'd78)) begin
                n_fails++;
                $display("[TB] FAIL chan_range step %0d: chan got %0d required <= 78", i, hop_chan);
            end
        end
        n_checks++;
        if (n_seen != n_req) begin
            n_fails++;
            $display("[TB] FAIL valid_count: got %0d pulses expected %0d", n_seen, n_req);
        end
    endtask

    initial begin
        test_reset();
        test_connection();
        test_page_scan();
        test_page();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
